// File: rtl/adc_sensor_conditioner_if.sv
// Bundle between the SPI ADC byte source and adc_sensor_conditioner.
// sample_valid is a one-cycle strobe with no back-pressure: levels, throttle and lamp_state are held between strobes.
interface adc_sensor_conditioner_if;
  logic [7:0] adc_accel;
  logic [7:0] adc_cds;
  logic [7:0] accel_level;
  logic [7:0] throttle;
  logic [7:0] cds_level;
  logic       headlight_on;
  logic       sample_valid;
  logic [1:0] lamp_state;

  modport master (
    output adc_accel, adc_cds,
    input  accel_level, throttle, cds_level, headlight_on, sample_valid, lamp_state
  );

  modport slave (
    input  adc_accel, adc_cds,
    output accel_level, throttle, cds_level, headlight_on, sample_valid, lamp_state
  );
endinterface

// File: rtl/adc_sensor_conditioner.sv
// Samples pedal and light-sensor ADC bytes at a fixed rate, smooths them, and derives throttle and auto-headlight.
// Optional moving-average filter enabled by defining ADC_COND_AVG_EN; otherwise levels are the raw captured samples.
module adc_sensor_conditioner #(
  parameter int SAMPLE_DIV = 50000,
  parameter int AVG_LOG2   = 3,
  parameter int DEAD_LO    = 16,
  parameter int DARK_ON    = 80,
  parameter int DARK_OFF   = 110,
  parameter int DARK_HOLD  = 200
) (
  input logic                      clk,
  input logic                      rst,
  adc_sensor_conditioner_if.slave  bus
);

  localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HOLD_W = $clog2(DARK_HOLD + 1);
  localparam logic [7:0] DEAD_LO_B  = 8'(DEAD_LO);
  localparam logic [7:0] DARK_ON_B  = 8'(DARK_ON);
  localparam logic [7:0] DARK_OFF_B = 8'(DARK_OFF);

  typedef enum logic [1:0] {
    ST_LIGHT      = 2'd0,
    ST_DARK_PEND  = 2'd1,
    ST_DARK       = 2'd2,
    ST_LIGHT_PEND = 2'd3
  } lamp_state_e;

  // Sample-rate tick
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  assign tick       = (tick_cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  // Stage 1: capture inputs on tick only
  logic [7:0] accel_smp_q, cds_smp_q;
  logic       smp_v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      accel_smp_q <= '0;
      cds_smp_q   <= '0;
      smp_v_q     <= 1'b0;
    end else begin
      smp_v_q <= tick;
      if (tick) begin
        accel_smp_q <= bus.adc_accel;
        cds_smp_q   <= bus.adc_cds;
      end
    end
  end

  // Stage 2: filter (or plain pipeline register when the filter is compiled out)
  logic [7:0] accel_s2, cds_s2;
  logic       s2_v_q;

`ifdef ADC_COND_AVG_EN
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = 8 + AVG_LOG2;

  logic [7:0]          accel_buf_q [DEPTH];
  logic [7:0]          cds_buf_q   [DEPTH];
  logic [SUM_W-1:0]    accel_sum_q, accel_sum_d;
  logic [SUM_W-1:0]    cds_sum_q, cds_sum_d;
  logic [AVG_LOG2-1:0] idx_q, idx_d;

  // Subtracting the evicted byte before the running sum is rewritten keeps it bounded by DEPTH*255.
  always_comb begin
    accel_sum_d = accel_sum_q - SUM_W'(accel_buf_q[idx_q]) + SUM_W'(accel_smp_q);
    cds_sum_d   = cds_sum_q   - SUM_W'(cds_buf_q[idx_q])   + SUM_W'(cds_smp_q);
    idx_d       = idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        accel_buf_q[i] <= '0;
        cds_buf_q[i]   <= '0;
      end
      accel_sum_q <= '0;
      cds_sum_q   <= '0;
      idx_q       <= '0;
      s2_v_q      <= 1'b0;
    end else begin
      s2_v_q <= smp_v_q;
      if (smp_v_q) begin
        accel_buf_q[idx_q] <= accel_smp_q;
        cds_buf_q[idx_q]   <= cds_smp_q;
        accel_sum_q        <= accel_sum_d;
        cds_sum_q          <= cds_sum_d;
        idx_q              <= idx_d;
      end
    end
  end

  assign accel_s2 = accel_sum_q[SUM_W-1:AVG_LOG2];
  assign cds_s2   = cds_sum_q[SUM_W-1:AVG_LOG2];
`else
  logic [7:0] accel_raw_q, cds_raw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      accel_raw_q <= '0;
      cds_raw_q   <= '0;
      s2_v_q      <= 1'b0;
    end else begin
      s2_v_q <= smp_v_q;
      if (smp_v_q) begin
        accel_raw_q <= accel_smp_q;
        cds_raw_q   <= cds_smp_q;
      end
    end
  end

  assign accel_s2 = accel_raw_q;
  assign cds_s2   = cds_raw_q;
`endif

  // Stage 3: registered levels and throttle
  logic [7:0] accel_level_q, cds_level_q, throttle_q, throttle_d;
  logic       sample_valid_q;
  logic [7:0] thr_diff;
  logic [8:0] thr_x2;

  always_comb begin
    thr_diff   = accel_s2 - DEAD_LO_B;
    thr_x2     = {thr_diff, 1'b0};
    throttle_d = '0;
    if (accel_s2 > DEAD_LO_B) begin
      throttle_d = thr_x2[8] ? 8'hFF : thr_x2[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accel_level_q  <= '0;
      cds_level_q    <= '0;
      throttle_q     <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      sample_valid_q <= s2_v_q;
      if (s2_v_q) begin
        accel_level_q <= accel_s2;
        cds_level_q   <= cds_s2;
        throttle_q    <= throttle_d;
      end
    end
  end

  // Lamp FSM: state register
  lamp_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              is_dark, is_light, hold_done;
  logic              headlight;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LIGHT;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  assign is_dark   = (cds_level_q < DARK_ON_B);
  assign is_light  = (cds_level_q > DARK_OFF_B);
  assign hold_inc  = hold_q + 1'b1;
  assign hold_done = (hold_inc == HOLD_W'(DARK_HOLD));

  // Lamp FSM: next state, evaluated only on the freshly registered cds level
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (sample_valid_q) begin
      case (state_q)
        ST_LIGHT: begin
          if (is_dark) begin
            if (DARK_HOLD == 1) begin
              state_d = ST_DARK;
              hold_d  = '0;
            end else begin
              state_d = ST_DARK_PEND;
              hold_d  = HOLD_W'(1);
            end
          end
        end
        ST_DARK_PEND: begin
          if (!is_dark) begin
            state_d = ST_LIGHT;
            hold_d  = '0;
          end else if (hold_done) begin
            state_d = ST_DARK;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
        end
        ST_DARK: begin
          if (is_light) begin
            if (DARK_HOLD == 1) begin
              state_d = ST_LIGHT;
              hold_d  = '0;
            end else begin
              state_d = ST_LIGHT_PEND;
              hold_d  = HOLD_W'(1);
            end
          end
        end
        ST_LIGHT_PEND: begin
          if (!is_light) begin
            state_d = ST_DARK;
            hold_d  = '0;
          end else if (hold_done) begin
            state_d = ST_LIGHT;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
        end
        default: begin
          state_d = ST_LIGHT;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Lamp FSM: outputs
  always_comb begin
    headlight = 1'b0;
    case (state_q)
      ST_DARK, ST_LIGHT_PEND: headlight = 1'b1;
      default:                headlight = 1'b0;
    endcase
  end

  assign bus.accel_level  = accel_level_q;
  assign bus.cds_level    = cds_level_q;
  assign bus.throttle     = throttle_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.headlight_on = headlight;
  assign bus.lamp_state   = state_q;

endmodule

// File: tb/tb_adc_sensor_conditioner.sv
// Directed table-driven bench for adc_sensor_conditioner; expectations track the ADC_COND_AVG_EN build option.
module tb_adc_sensor_conditioner;

  localparam int SAMPLE_DIV = 4;
  localparam int AVG_LOG2   = 3;
  localparam int DEAD_LO    = 16;
  localparam int DARK_ON    = 80;
  localparam int DARK_OFF   = 110;
  localparam int DARK_HOLD  = 3;
  localparam int NVEC       = 20;
  localparam int W          = 25;

  typedef struct {
    logic [7:0] accel;
    logic [7:0] cds;
    logic [7:0] exp_accel;
    logic [7:0] exp_thr;
    logic [7:0] exp_cds;
    logic       exp_hl;
    logic       after_rst;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [NVEC];
  logic [W-1:0] exp_q [$];

  adc_sensor_conditioner_if bus ();

  adc_sensor_conditioner #(
    .SAMPLE_DIV (SAMPLE_DIV),
    .AVG_LOG2   (AVG_LOG2),
    .DEAD_LO    (DEAD_LO),
    .DARK_ON    (DARK_ON),
    .DARK_OFF   (DARK_OFF),
    .DARK_HOLD  (DARK_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock/reset
  always #5 clk = ~clk;

  function automatic vec_t mk(input int a, input int c, input int ea, input int et,
                              input int ec, input int eh, input int ar);
    vec_t v;
    v.accel     = 8'(a);
    v.cds       = 8'(c);
    v.exp_accel = 8'(ea);
    v.exp_thr   = 8'(et);
    v.exp_cds   = 8'(ec);
    v.exp_hl    = 1'(eh);
    v.after_rst = 1'(ar);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver: synchronous reset for one edge, then check the cleared state
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_accel_level", int'(bus.accel_level), 0);
    check("rst_cds_level", int'(bus.cds_level), 0);
    check("rst_throttle", int'(bus.throttle), 0);
    check("rst_headlight", int'(bus.headlight_on), 0);
    check("rst_valid", int'(bus.sample_valid), 0);
    check("rst_lamp_state", int'(bus.lamp_state), 0);
    rst = 1'b0;
  endtask

  // Driver: present one sample, wait for its strobe, score levels then headlight
  task automatic apply_vec(input int k, input vec_t v);
    int n;
    logic [W-1:0] e;
    bit found;
    bus.adc_accel = v.accel;
    bus.adc_cds   = v.cds;
    exp_q.push_back({v.exp_accel, v.exp_thr, v.exp_cds, v.exp_hl});
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (!v.after_rst && n == 1) begin
        bus.adc_accel = 8'($urandom_range(0, 255));
        bus.adc_cds   = 8'($urandom_range(0, 255));
      end
      found = bus.sample_valid;
    end
    e = exp_q.pop_front();
    if (!found) begin
      check($sformatf("v%0d_valid_timeout", k), 0, 1);
      return;
    end
    check($sformatf("v%0d_valid_cycles", k), n, v.after_rst ? SAMPLE_DIV + 2 : SAMPLE_DIV - 1);
    check($sformatf("v%0d_accel_level", k), int'(bus.accel_level), int'(e[24:17]));
    check($sformatf("v%0d_throttle", k), int'(bus.throttle), int'(e[16:9]));
    check($sformatf("v%0d_cds_level", k), int'(bus.cds_level), int'(e[8:1]));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_headlight", k), int'(bus.headlight_on), int'(e[0]));
    check($sformatf("v%0d_valid_low", k), int'(bus.sample_valid), 0);
    check($sformatf("v%0d_accel_hold", k), int'(bus.accel_level), int'(e[24:17]));
  endtask

  initial begin
    bus.adc_accel = '0;
    bus.adc_cds   = '0;
`ifdef ADC_COND_AVG_EN
    // Ramp from empty history, then step down, reset while in LIGHT_PEND, ramp again
    vecs[0]  = mk(200,  50,  25,  18,   6, 0, 1);
    vecs[1]  = mk(200,  50,  50,  68,  12, 0, 0);
    vecs[2]  = mk(200,  50,  75, 118,  18, 1, 0);
    vecs[3]  = mk(200,  50, 100, 168,  25, 1, 0);
    vecs[4]  = mk(200,  50, 125, 218,  31, 1, 0);
    vecs[5]  = mk(200,  50, 150, 255,  37, 1, 0);
    vecs[6]  = mk(200,  50, 175, 255,  43, 1, 0);
    vecs[7]  = mk(200,  50, 200, 255,  50, 1, 0);
    vecs[8]  = mk( 10, 200, 176, 255,  68, 1, 0);
    vecs[9]  = mk( 10, 200, 152, 255,  87, 1, 0);
    vecs[10] = mk( 10, 200, 128, 224, 106, 1, 0);
    vecs[11] = mk( 10, 200, 105, 178, 125, 1, 0);
    vecs[12] = mk(200, 200,  25,  18,  25, 0, 1);
    vecs[13] = mk(200, 200,  50,  68,  50, 0, 0);
    vecs[14] = mk(200, 200,  75, 118,  75, 1, 0);
    vecs[15] = mk(200, 200, 100, 168, 100, 1, 0);
    vecs[16] = mk(200, 200, 125, 218, 125, 1, 0);
    vecs[17] = mk(200, 200, 150, 255, 150, 1, 0);
    vecs[18] = mk(200, 200, 175, 255, 175, 0, 0);
    vecs[19] = mk(200, 200, 200, 255, 200, 0, 0);
`else
    // Raw levels: dead zone edges, saturation, pend aborts, hold count, reset in LIGHT_PEND
    vecs[0]  = mk(200, 200, 200, 255, 200, 0, 1);
    vecs[1]  = mk( 20,  50,  20,   8,  50, 0, 0);
    vecs[2]  = mk( 16,  50,  16,   0,  50, 0, 0);
    vecs[3]  = mk( 17,  95,  17,   2,  95, 0, 0);
    vecs[4]  = mk(  0,  50,   0,   0,  50, 0, 0);
    vecs[5]  = mk(143,  79, 143, 254,  79, 0, 0);
    vecs[6]  = mk(144,  50, 144, 255,  50, 1, 0);
    vecs[7]  = mk(255, 110, 255, 255, 110, 1, 0);
    vecs[8]  = mk(100, 111, 100, 168, 111, 1, 0);
    vecs[9]  = mk( 30, 200,  30,  28, 200, 1, 0);
    vecs[10] = mk( 30, 100,  30,  28, 100, 1, 0);
    vecs[11] = mk( 30, 200,  30,  28, 200, 1, 0);
    vecs[12] = mk( 30, 200,  30,  28, 200, 1, 0);
    vecs[13] = mk( 30, 200,  30,  28, 200, 0, 0);
    vecs[14] = mk( 30,  50,  30,  28,  50, 0, 0);
    vecs[15] = mk( 30,  50,  30,  28,  50, 0, 0);
    vecs[16] = mk( 30,  50,  30,  28,  50, 1, 0);
    vecs[17] = mk( 30, 200,  30,  28, 200, 1, 0);
    vecs[18] = mk(200, 200, 200, 255, 200, 0, 1);
    vecs[19] = mk( 10,  50,  10,   0,  50, 0, 0);
`endif
    for (int k = 0; k < NVEC; k++) begin
      if (vecs[k].after_rst) do_reset();
      apply_vec(k, vecs[k]);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
